// File: rtl/clk_rst_seq.sv
// Sequences the write/read clock-divider resets: staggered bring-up, settle, ready,
// and a reverse-order shutdown. All outputs are registered and decoded from the next state.
module clk_rst_seq #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned SETTLE      = 6,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic       w_rst,
  output logic       r_rst,
  output logic       ready,
  output logic       busy,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    HOLD   = 3'd1,
    WREL   = 3'd2,
    RREL   = 3'd3,
    RUN    = 3'd4,
    STOP_R = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LD = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done;

  assign done    = (cnt == '0);
  assign state_o = state;

  // stop outranks start everywhere; an abort before r_rst release can park both at once
  always_comb begin
    state_nx = state;
    cnt_nx   = done ? cnt : cnt - CNT_W'(1);
    unique case (state)
      OFF: begin
        if (start && !stop) begin
          state_nx = HOLD;
          cnt_nx   = HOLD_LD;
        end
      end
      HOLD: begin
        if (stop) begin
          state_nx = OFF;
          cnt_nx   = '0;
        end else if (done) begin
          state_nx = WREL;
          cnt_nx   = STAGGER_LD;
        end
      end
      WREL: begin
        if (stop) begin
          state_nx = OFF;
          cnt_nx   = '0;
        end else if (done) begin
          state_nx = RREL;
          cnt_nx   = SETTLE_LD;
        end
      end
      RREL: begin
        if (stop) begin
          state_nx = STOP_R;
          cnt_nx   = STAGGER_LD;
        end else if (done) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = STOP_R;
          cnt_nx   = STAGGER_LD;
        end
      end
      STOP_R: begin
        if (done) begin
          state_nx = OFF;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = OFF;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
      w_rst <= 1'b1;
      r_rst <= 1'b1;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      w_rst <= (state_nx == OFF) || (state_nx == HOLD);
      r_rst <= (state_nx != RREL) && (state_nx != RUN);
      ready <= (state_nx == RUN);
      busy  <= (state_nx != OFF) && (state_nx != RUN);
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: two instances (default and minimal timing) checked every cycle
// against a timestamp-based model, plus literal timing checks for the documented scenarios.
module tb_clk_rst_seq;

  logic       clk, rst, start, stop;
  logic [1:0] w_r, r_r, rdy, bsy;
  logic [2:0] st [2];

  int n_pass = 0;
  int n_tot  = 0;

  // model per instance: mode 0 idle, 1 bringing up (t = edges since start), 2 run, 3 stopping
  int mode [2] = '{0, 0};
  int t    [2] = '{0, 0};

  clk_rst_seq #(.HOLD_CYCLES(8), .STAGGER(4), .SETTLE(6), .CNT_W(8)) u_dflt (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .w_rst(w_r[0]), .r_rst(r_r[0]), .ready(rdy[0]), .busy(bsy[0]), .state_o(st[0])
  );

  clk_rst_seq #(.HOLD_CYCLES(1), .STAGGER(1), .SETTLE(1), .CNT_W(2)) u_fast (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .w_rst(w_r[1]), .r_rst(r_r[1]), .ready(rdy[1]), .busy(bsy[1]), .state_o(st[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int p_h(input int u);  return (u == 0) ? 8 : 1; endfunction
  function automatic int p_s(input int u);  return (u == 0) ? 4 : 1; endfunction
  function automatic int p_se(input int u); return (u == 0) ? 6 : 1; endfunction

  function automatic int phase(input int u, input int tt);
    if (tt < p_h(u)) return 1;
    if (tt < p_h(u) + p_s(u)) return 2;
    if (tt < p_h(u) + p_s(u) + p_se(u)) return 3;
    return 4;
  endfunction

  function automatic int exp_state(input int u);
    case (mode[u])
      1:       return phase(u, t[u]);
      2:       return 4;
      3:       return 5;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input int u);
    if (rst) begin
      mode[u] = 0;
    end else begin
      case (mode[u])
        0: if (start && !stop) begin mode[u] = 1; t[u] = 0; end
        1: begin
          if (stop) begin
            if (phase(u, t[u]) == 3) begin mode[u] = 3; t[u] = 0; end
            else mode[u] = 0;
          end else begin
            t[u]++;
            if (t[u] >= p_h(u) + p_s(u) + p_se(u)) mode[u] = 2;
          end
        end
        2: if (stop) begin mode[u] = 3; t[u] = 0; end
        default: begin
          t[u]++;
          if (t[u] >= p_s(u)) mode[u] = 0;
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) model_step(u);
    #1;
    for (int u = 0; u < 2; u++) begin
      int es;
      es = exp_state(u);
      chk($sformatf("state_o[%0d]", u), int'(st[u]), es);
      chk($sformatf("w_rst[%0d]", u), int'(w_r[u]), (es <= 1) ? 1 : 0);
      chk($sformatf("r_rst[%0d]", u), int'(r_r[u]), (es == 3 || es == 4) ? 0 : 1);
      chk($sformatf("ready[%0d]", u), int'(rdy[u]), (es == 4) ? 1 : 0);
      chk($sformatf("busy[%0d]", u), int'(bsy[u]), (es == 0 || es == 4) ? 0 : 1);
      chk($sformatf("inv_rrst_wrst[%0d]", u), int'(!r_r[u] && w_r[u]), 0);
      chk($sformatf("inv_busy_ready[%0d]", u), int'(bsy[u] && rdy[u]), 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(20);
    chk("idle_state", int'(st[0]), 0);
    chk("idle_w_rst", int'(w_r[0]), 1);
    chk("idle_busy", int'(bsy[0]), 0);

    // bring-up: start pulse sampled at edge k
    start = 1'b1; tick();
    start = 1'b0;
    chk("up_k_busy", int'(bsy[0]), 1);
    chk("up_k_w_rst", int'(w_r[0]), 1);
    chk("fast_k_w_rst", int'(w_r[1]), 1);
    tick();
    chk("fast_k1_w_rst", int'(w_r[1]), 0);
    chk("fast_k1_r_rst", int'(r_r[1]), 1);
    tick();
    chk("fast_k2_r_rst", int'(r_r[1]), 0);
    chk("fast_k2_ready", int'(rdy[1]), 0);
    tick();
    chk("fast_k3_ready", int'(rdy[1]), 1);
    tick(4);
    chk("up_k7_w_rst", int'(w_r[0]), 1);
    tick();
    chk("up_k8_w_rst", int'(w_r[0]), 0);
    chk("up_k8_r_rst", int'(r_r[0]), 1);
    tick(3);
    chk("up_k11_r_rst", int'(r_r[0]), 1);
    tick();
    chk("up_k12_r_rst", int'(r_r[0]), 0);
    tick(5);
    chk("up_k17_ready", int'(rdy[0]), 0);
    chk("up_k17_busy", int'(bsy[0]), 1);
    tick();
    chk("up_k18_ready", int'(rdy[0]), 1);
    chk("up_k18_busy", int'(bsy[0]), 0);
    chk("up_k18_state", int'(st[0]), 4);

    // shutdown from RUN: stop sampled at edge m
    stop = 1'b1; tick();
    stop = 1'b0;
    chk("dn_m_ready", int'(rdy[0]), 0);
    chk("dn_m_r_rst", int'(r_r[0]), 1);
    chk("dn_m_w_rst", int'(w_r[0]), 0);
    chk("dn_m_state", int'(st[0]), 5);
    tick(3);
    chk("dn_m3_w_rst", int'(w_r[0]), 0);
    chk("dn_m3_busy", int'(bsy[0]), 1);
    tick();
    chk("dn_m4_w_rst", int'(w_r[0]), 1);
    chk("dn_m4_state", int'(st[0]), 0);
    chk("dn_m4_busy", int'(bsy[0]), 0);

    // aborts in HOLD, WREL, RREL
    start = 1'b1; tick(); start = 1'b0;
    tick(3);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("ab_hold_state", int'(st[0]), 0);
    chk("ab_hold_w_rst", int'(w_r[0]), 1);
    start = 1'b1; tick(); start = 1'b0;
    tick(8);
    chk("ab_wrel_pre", int'(st[0]), 2);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("ab_wrel_state", int'(st[0]), 0);
    chk("ab_wrel_w_rst", int'(w_r[0]), 1);
    chk("ab_wrel_r_rst", int'(r_r[0]), 1);
    start = 1'b1; tick(); start = 1'b0;
    tick(12);
    chk("ab_rrel_pre", int'(st[0]), 3);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("ab_rrel_r_rst", int'(r_r[0]), 1);
    chk("ab_rrel_w_rst", int'(w_r[0]), 0);
    chk("ab_rrel_state", int'(st[0]), 5);
    tick(3);
    chk("ab_rrel_s3_w_rst", int'(w_r[0]), 0);
    tick();
    chk("ab_rrel_s4_w_rst", int'(w_r[0]), 1);
    chk("ab_rrel_s4_state", int'(st[0]), 0);

    // priority and ignored start
    start = 1'b1; stop = 1'b1; tick();
    chk("both_off_state", int'(st[0]), 0);
    stop = 1'b0;
    tick(19);
    chk("held_run_state", int'(st[0]), 4);
    tick(10);
    chk("held_run_norestart", int'(st[0]), 4);
    chk("held_run_ready", int'(rdy[0]), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("held_stop_state", int'(st[0]), 5);
    tick(3);
    chk("held_stop_m3", int'(st[0]), 5);
    tick();
    chk("held_stop_off", int'(st[0]), 0);
    tick();
    chk("held_restart", int'(st[0]), 1);
    start = 1'b0;
    tick(18);
    chk("restart_ready", int'(rdy[0]), 1);

    // reset during RREL
    stop = 1'b1; tick(); stop = 1'b0;
    tick(4);
    start = 1'b1; tick(); start = 1'b0;
    tick(12);
    chk("rst_mid_pre", int'(st[0]), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_state", int'(st[0]), 0);
    chk("rst_mid_w_rst", int'(w_r[0]), 1);
    chk("rst_mid_r_rst", int'(r_r[0]), 1);
    chk("rst_mid_ready", int'(rdy[0]), 0);
    chk("rst_mid_busy", int'(bsy[0]), 0);

    // randomized traffic, model compared every cycle
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
Sequencer for the write/read clock divider resets (w_rst, r_rst) that feed the dual-clock FIFO domains.
- Bring-up: holds both divided clocks parked, then releases wclk before rclk with a programmable stagger.
- Settle: waits for both divided clocks to complete whole periods, then flags ready.
- Shutdown: parks the domains in reverse order (read first, then write).
- Sits between top-level control and the clock divider; its outputs drive the divider reset inputs directly.

Parameters:
HOLD_CYCLES, 8, clk cycles both divider resets stay asserted after start (>=1)
STAGGER, 4, clk cycles between w_rst release and r_rst release, and between r_rst and w_rst re-assertion on stop (>=1)
SETTLE, 6, clk cycles after r_rst release before ready (6 = LCM of ÷2 and ÷3; >=1)
CNT_W, 8, width of internal down-counter; must hold max(HOLD_CYCLES, STAGGER, SETTLE)-1

Ports:
clk  input  1  system clock (divider input clock)
rst  input  1  synchronous, active-high reset
start  input  1  bring-up request, sampled each edge (level or pulse)
stop  input  1  shutdown request, sampled each edge
w_rst  output  1  registered, to divider write-clock reset (1 = wclk parked low)
r_rst  output  1  registered, to divider read-clock reset (1 = rclk parked low)
ready  output  1  registered, both domains running and settled
busy  output  1  registered, sequence in progress (any state except OFF/RUN)
state_o  output  3  current state encoding, debug

Behaviour:
- Single clock domain. All outputs are registered and decoded from the next state.
- rst (sync, high) -> state OFF, counter 0, w_rst=1, r_rst=1, ready=0, busy=0. rst overrides all inputs, including mid-sequence.
- State encodings: OFF=0, HOLD=1, WREL=2, RREL=3, RUN=4, STOP_R=5.
- Counter: loaded with N-1 on state entry, decrements each cycle. Leave the state when counter==0, so the state lasts exactly N cycles.
- OFF: w_rst=1, r_rst=1. start=1 and stop=0 -> HOLD (load HOLD_CYCLES).
- HOLD: w_rst=1, r_rst=1, busy=1. Done -> WREL (load STAGGER).
- WREL: w_rst=0, r_rst=1, busy=1. Done -> RREL (load SETTLE).
- RREL: w_rst=0, r_rst=0, busy=1. Done -> RUN.
- RUN: w_rst=0, r_rst=0, ready=1, busy=0. stop=1 -> STOP_R (load STAGGER).
- STOP_R: w_rst=0, r_rst=1, ready=0, busy=1. Done -> OFF (w_rst=1).
- Timing from edge k where start is sampled in OFF:
  - w_rst falls at edge k+HOLD_CYCLES
  - r_rst falls at edge k+HOLD_CYCLES+STAGGER
  - ready rises at edge k+HOLD_CYCLES+STAGGER+SETTLE
- Timing from edge m where stop is sampled in RUN:
  - ready=0 and r_rst=1 at edge m
  - w_rst=1 at edge m+STAGGER
- stop has priority over start in every state. start+stop together in OFF -> stay OFF.
- stop during HOLD -> OFF next edge.
- stop during WREL -> OFF next edge; w_rst re-asserts, r_rst stays 1.
- stop during RREL -> STOP_R (load STAGGER); r_rst re-asserts next edge.
- start in any state except OFF is ignored. start in STOP_R does not abort shutdown; a new start must be sampled in OFF.
- Invariants:
  - r_rst=0 implies w_rst=0, always (read domain never runs without write domain).
  - ready=1 only in RUN.
  - busy and ready are never both 1.
  - Outputs never glitch; all change on clk edges only.
- The counter never wraps: it is only decremented while nonzero, then reloaded on entry to the next state.

Test Plan:
- Reset then idle: rst high 3 cycles, start=0 for 20 cycles -> w_rst=1, r_rst=1, ready=0, busy=0, state_o=0 throughout.
- Bring-up with defaults: start pulse sampled at edge 10 -> w_rst falls at edge 18, r_rst falls at 22, ready rises at 28, busy high over edges 10-27.
- Shutdown: in RUN, stop sampled at edge 40 -> ready=0 and r_rst=1 at 40, w_rst=1 at 44, busy high edges 40-43, then state OFF.
- Abort mid-sequence: stop at edge 14 (HOLD) -> OFF at 14. Stop in WREL -> w_rst=1 next edge. Stop in RREL -> r_rst=1 next edge, w_rst=1 STAGGER cycles later. Invariant r_rst=0 implies w_rst=0 is checked every cycle.
- Priority and ignore: start and stop together in OFF -> stays OFF. start held high through RUN -> no restart. start in STOP_R -> ends in OFF, then a new start sampled in OFF restarts the full sequence.
- Reset mid-operation and params: rst asserted in RREL -> next edge w_rst=1, r_rst=1, ready=0, state OFF. Rerun bring-up with HOLD_CYCLES=1, STAGGER=1, SETTLE=1 -> w_rst falls at k+1, r_rst at k+2, ready at k+3.
